// File: rtl/axi_router_pkg.sv
// Shared definitions for the AXI address router: default address map,
// derived counter states and the priority base/mask decode function.
package axi_router_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_SLAVE_NUM  = 3;

  // Upper bounds used by the width-independent decode function
  localparam int MAX_SLAVE_NUM  = 16;
  localparam int MAX_ADDR_WIDTH = 64;

  // Slave i occupies slice i (slice 0 is the rightmost word)
  localparam logic [DEF_SLAVE_NUM*DEF_ADDR_WIDTH-1:0] DEF_SLAVE_BASE =
    {32'h1000_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [DEF_SLAVE_NUM*DEF_ADDR_WIDTH-1:0] DEF_SLAVE_MASK =
    {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  // Occupancy view of the outstanding counter
  typedef enum logic [1:0] {
    CNT_IDLE,
    CNT_ACTIVE,
    CNT_FULL
  } cntState_e;

  // Returns a one-hot target: lowest matching slave index wins,
  // bit slaveNum marks the DECERR pseudo-slave when nothing matches.
  function automatic logic [MAX_SLAVE_NUM:0] decodeTarget(
    input logic [MAX_ADDR_WIDTH-1:0]               addr,
    input logic [MAX_SLAVE_NUM*MAX_ADDR_WIDTH-1:0] base,
    input logic [MAX_SLAVE_NUM*MAX_ADDR_WIDTH-1:0] mask,
    input int                                      slaveNum
  );
    logic [MAX_SLAVE_NUM:0] tgt;
    logic                   found;
    tgt   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_SLAVE_NUM; i++) begin
      if (!found && (i < slaveNum) &&
          ((addr & mask[i*MAX_ADDR_WIDTH +: MAX_ADDR_WIDTH]) ==
           base[i*MAX_ADDR_WIDTH +: MAX_ADDR_WIDTH])) begin
        tgt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    if (!found) begin
      tgt[slaveNum[4:0]] = 1'b1;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/addr_range_match.sv
// Purely combinational priority base/mask matcher. Produces a
// (SLAVE_NUM+1)-bit one-hot target; the top bit is the DECERR slave.
module addr_range_match
  import axi_router_pkg::*;
#(
  parameter int                                SLAVE_NUM  = DEF_SLAVE_NUM,
  parameter int                                ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0]   SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0]   SLAVE_MASK = DEF_SLAVE_MASK
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [SLAVE_NUM:0]    o_target
);

  logic [MAX_ADDR_WIDTH-1:0]               w_addrPad;
  logic [MAX_SLAVE_NUM*MAX_ADDR_WIDTH-1:0] w_basePad;
  logic [MAX_SLAVE_NUM*MAX_ADDR_WIDTH-1:0] w_maskPad;
  logic [MAX_SLAVE_NUM:0]                  w_full;
  logic                                    w_unused;

  // Widen address and map into the fixed-size layout the decode function expects
  always_comb begin
    w_addrPad = '0;
    w_basePad = '0;
    w_maskPad = '0;
    w_addrPad[ADDR_WIDTH-1:0] = i_addr;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      w_basePad[i*MAX_ADDR_WIDTH +: ADDR_WIDTH] = SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_maskPad[i*MAX_ADDR_WIDTH +: ADDR_WIDTH] = SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign w_full   = decodeTarget(w_addrPad, w_basePad, w_maskPad, SLAVE_NUM);
  assign o_target = w_full[SLAVE_NUM:0];
  assign w_unused = ^w_full;

endmodule

// File: rtl/axi_addr_router.sv
// AXI address router: decodes AxADDR to a one-hot slave select (or DECERR),
// registers it behind a valid/ready stage and stalls requests to a different
// slave while earlier transactions are still outstanding.
// Optional: define AXI_ROUTER_STALL_CNT_EN to add the 16-bit saturating
// stall_cnt output counting ordering/full stalls.
module axi_addr_router
  import axi_router_pkg::*;
#(
  parameter int                              SLAVE_NUM       = DEF_SLAVE_NUM,
  parameter int                              ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int                              MAX_OUTSTANDING = 4,
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLAVE_BASE      = DEF_SLAVE_BASE,
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLAVE_MASK      = DEF_SLAVE_MASK
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETn,
  input  logic [ADDR_WIDTH-1:0]                  s_addr,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  output logic [ADDR_WIDTH-1:0]                  m_addr,
  output logic [SLAVE_NUM-1:0]                   m_select,
  output logic                                   m_decerr,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  input  logic                                   rsp_done,
`ifdef AXI_ROUTER_STALL_CNT_EN
  output logic [15:0]                            stall_cnt,
`endif
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

  localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SLAVE_NUM:0]    w_target;
  logic                  w_block;
  logic                  w_accept;
  logic                  w_rspDec;
  cntState_e             w_cntState;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [SLAVE_NUM-1:0]  r_select;
  logic                  r_decerr;
  logic                  r_valid;
  logic [CNT_W-1:0]      r_cnt;
  logic [SLAVE_NUM:0]    r_lastTgt;

  addr_range_match #(
    .SLAVE_NUM  (SLAVE_NUM),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_match (
    .i_addr   (s_addr),
    .o_target (w_target)
  );

  // Registered state only: a same-cycle rsp_done does not unblock
  assign w_block  = (r_cnt == CNT_MAX) || ((r_cnt != '0) && (w_target != r_lastTgt));
  assign s_ready  = (!r_valid || m_ready) && !w_block;
  assign w_accept = s_valid && s_ready;
  assign w_rspDec = rsp_done && (r_cnt != '0);

  // Output stage and outstanding counter
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_addr    <= '0;
      r_select  <= '0;
      r_decerr  <= 1'b0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
      r_lastTgt <= '0;
    end else begin
      if (w_accept) begin
        r_addr    <= s_addr;
        r_select  <= w_target[SLAVE_NUM-1:0];
        r_decerr  <= w_target[SLAVE_NUM];
        r_lastTgt <= w_target;
        r_valid   <= 1'b1;
      end else if (m_ready) begin
        r_valid   <= 1'b0;
      end
      if (w_accept && !w_rspDec) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else if (!w_accept && w_rspDec) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  // Occupancy classification of the counter, used by the checks below
  always_comb begin
    w_cntState = CNT_ACTIVE;
    if (r_cnt == '0) begin
      w_cntState = CNT_IDLE;
    end else if (r_cnt == CNT_MAX) begin
      w_cntState = CNT_FULL;
    end
  end

  assign m_addr      = r_addr;
  assign m_select    = r_select;
  assign m_decerr    = r_decerr;
  assign m_valid     = r_valid;
  assign outstanding = r_cnt;

`ifdef AXI_ROUTER_STALL_CNT_EN
  logic        w_stall;
  logic [15:0] r_stallCnt;

  assign w_stall = s_valid && (!r_valid || m_ready) && w_block;

  // Saturating count of cycles lost to ordering or full stalls
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_stallCnt <= '0;
    end else if (w_stall && (r_stallCnt != 16'hFFFF)) begin
      r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

  assign stall_cnt = r_stallCnt;
`endif

  a_rspWhileIdle: assert property (@(posedge ACLK) disable iff (!ARESETn)
    rsp_done |-> (w_cntState != CNT_IDLE));

  a_noAcceptWhenFull: assert property (@(posedge ACLK) disable iff (!ARESETn)
    (w_cntState == CNT_FULL) |-> !s_ready);

endmodule

// File: tb/tb_axi_addr_router.sv
// Self-checking bench for axi_addr_router with the default 3-slave map.
// Each table row is one clock: inputs are driven, s_ready is compared
// before the edge, registered outputs are compared after it.
module tb_axi_addr_router;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] s_addr;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_addr;
  logic [2:0]  m_select;
  logic        m_decerr;
  logic        m_valid;
  logic        m_ready;
  logic        rsp_done;
  logic [2:0]  outstanding;
`ifdef AXI_ROUTER_STALL_CNT_EN
  logic [15:0] stallCnt;
`endif

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        valid;
    logic        mReady;
    logic        rspDone;
    logic        expSReady;
    logic        expMValid;
    logic [2:0]  expSelect;
    logic        expDecerr;
    logic [2:0]  expOut;
    logic [31:0] expMAddr;
  } vecT;

  localparam int NUM_VEC = 30;
  vecT vecs [NUM_VEC];

  axi_addr_router dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .s_addr      (s_addr),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_addr      (m_addr),
    .m_select    (m_select),
    .m_decerr    (m_decerr),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .rsp_done    (rsp_done),
`ifdef AXI_ROUTER_STALL_CNT_EN
    .stall_cnt   (stallCnt),
`endif
    .outstanding (outstanding)
  );

  always #5 ACLK = ~ACLK;

  function automatic vecT mk(input logic [31:0] addr, input logic valid,
                             input logic mReady, input logic rspDone,
                             input logic expSReady, input logic expMValid,
                             input logic [2:0] expSelect, input logic expDecerr,
                             input logic [2:0] expOut, input logic [31:0] expMAddr);
    vecT v;
    v.addr = addr; v.valid = valid; v.mReady = mReady; v.rspDone = rspDone;
    v.expSReady = expSReady; v.expMValid = expMValid; v.expSelect = expSelect;
    v.expDecerr = expDecerr; v.expOut = expOut; v.expMAddr = expMAddr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vecT v, input int idx);
    s_addr   = v.addr;
    s_valid  = v.valid;
    m_ready  = v.mReady;
    rsp_done = v.rspDone;
    #1;
    checkOutput($sformatf("row%0d s_ready", idx), 32'(s_ready), 32'(v.expSReady));
    @(posedge ACLK);
    #1;
    checkOutput($sformatf("row%0d m_valid", idx), 32'(m_valid), 32'(v.expMValid));
    checkOutput($sformatf("row%0d outstanding", idx), 32'(outstanding), 32'(v.expOut));
    if (v.expMValid) begin
      checkOutput($sformatf("row%0d m_select", idx), 32'(m_select), 32'(v.expSelect));
      checkOutput($sformatf("row%0d m_decerr", idx), 32'(m_decerr), 32'(v.expDecerr));
      checkOutput($sformatf("row%0d m_addr", idx), m_addr, v.expMAddr);
    end
  endtask

  initial begin
    //               addr          v  mr rsp sr mv sel    dec out     maddr
    // map decode, each followed by a drain
    vecs[0]  = mk(32'h0001_2340, 1, 1, 0, 1, 1, 3'b010, 0, 3'd1, 32'h0001_2340);
    vecs[1]  = mk(32'h0001_2340, 0, 1, 1, 1, 0, 3'b000, 0, 3'd0, 32'h0);
    vecs[2]  = mk(32'h1234_0000, 1, 1, 0, 1, 1, 3'b100, 0, 3'd1, 32'h1234_0000);
    vecs[3]  = mk(32'h1234_0000, 0, 1, 1, 1, 0, 3'b000, 0, 3'd0, 32'h0);
    vecs[4]  = mk(32'h0000_0010, 1, 1, 0, 1, 1, 3'b001, 0, 3'd1, 32'h0000_0010);
    vecs[5]  = mk(32'h0000_0010, 0, 1, 1, 1, 0, 3'b000, 0, 3'd0, 32'h0);
    // miss -> DECERR
    vecs[6]  = mk(32'h2000_0000, 1, 1, 0, 1, 1, 3'b000, 1, 3'd1, 32'h2000_0000);
    // slave0 blocked behind DECERR until cnt reads 0
    vecs[7]  = mk(32'h0000_0000, 1, 1, 0, 0, 0, 3'b000, 0, 3'd1, 32'h0);
    vecs[8]  = mk(32'h0000_0000, 1, 1, 1, 0, 0, 3'b000, 0, 3'd0, 32'h0);
    vecs[9]  = mk(32'h0000_0000, 1, 1, 0, 1, 1, 3'b001, 0, 3'd1, 32'h0000_0000);
    // slave1 blocked behind slave0
    vecs[10] = mk(32'h0001_0000, 1, 1, 0, 0, 0, 3'b000, 0, 3'd1, 32'h0);
    vecs[11] = mk(32'h0001_0000, 1, 1, 1, 0, 0, 3'b000, 0, 3'd0, 32'h0);
    vecs[12] = mk(32'h0001_0000, 1, 1, 0, 1, 1, 3'b010, 0, 3'd1, 32'h0001_0000);
    vecs[13] = mk(32'h0000_0000, 0, 1, 1, 0, 0, 3'b000, 0, 3'd0, 32'h0);
    // fill to MAX_OUTSTANDING
    vecs[14] = mk(32'h0000_0100, 1, 1, 0, 1, 1, 3'b001, 0, 3'd1, 32'h0000_0100);
    vecs[15] = mk(32'h0000_0100, 1, 1, 0, 1, 1, 3'b001, 0, 3'd2, 32'h0000_0100);
    vecs[16] = mk(32'h0000_0100, 1, 1, 0, 1, 1, 3'b001, 0, 3'd3, 32'h0000_0100);
    vecs[17] = mk(32'h0000_0100, 1, 1, 0, 1, 1, 3'b001, 0, 3'd4, 32'h0000_0100);
    vecs[18] = mk(32'h0000_0100, 1, 1, 0, 0, 0, 3'b000, 0, 3'd4, 32'h0);
    vecs[19] = mk(32'h0000_0100, 1, 1, 1, 0, 0, 3'b000, 0, 3'd3, 32'h0);
    vecs[20] = mk(32'h0000_0100, 1, 1, 0, 1, 1, 3'b001, 0, 3'd4, 32'h0000_0100);
    vecs[21] = mk(32'h0000_0100, 0, 1, 1, 0, 0, 3'b000, 0, 3'd3, 32'h0);
    vecs[22] = mk(32'h0000_0100, 0, 1, 1, 1, 0, 3'b000, 0, 3'd2, 32'h0);
    // backpressure: output must hold for three cycles
    vecs[23] = mk(32'h0000_0200, 1, 0, 0, 1, 1, 3'b001, 0, 3'd3, 32'h0000_0200);
    vecs[24] = mk(32'h0000_0300, 1, 0, 0, 0, 1, 3'b001, 0, 3'd3, 32'h0000_0200);
    vecs[25] = mk(32'h0000_0300, 1, 0, 0, 0, 1, 3'b001, 0, 3'd3, 32'h0000_0200);
    vecs[26] = mk(32'h0000_0300, 1, 0, 0, 0, 1, 3'b001, 0, 3'd3, 32'h0000_0200);
    // accept together with rsp_done leaves the count unchanged
    vecs[27] = mk(32'h0000_0300, 1, 1, 1, 1, 1, 3'b001, 0, 3'd3, 32'h0000_0300);
    vecs[28] = mk(32'h0000_0300, 0, 1, 0, 1, 0, 3'b000, 0, 3'd3, 32'h0);
    vecs[29] = mk(32'h0000_0400, 1, 1, 1, 1, 1, 3'b001, 0, 3'd3, 32'h0000_0400);

    ARESETn  = 1'b0;
    s_addr   = '0;
    s_valid  = 1'b0;
    m_ready  = 1'b1;
    rsp_done = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    checkOutput("reset m_valid", 32'(m_valid), 32'd0);
    checkOutput("reset m_addr", m_addr, 32'd0);
    checkOutput("reset m_select", 32'(m_select), 32'd0);
    checkOutput("reset m_decerr", 32'(m_decerr), 32'd0);
    checkOutput("reset outstanding", 32'(outstanding), 32'd0);
`ifdef AXI_ROUTER_STALL_CNT_EN
    checkOutput("reset stall_cnt", 32'(stallCnt), 32'd0);
`endif
    ARESETn = 1'b1;

    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vecs[i], i);
    end

`ifdef AXI_ROUTER_STALL_CNT_EN
    checkOutput("stall_cnt after table", 32'(stallCnt), 32'd6);
`endif

    // reset in the middle of operation: m_valid=1, outstanding=3
    ARESETn  = 1'b0;
    s_addr   = 32'h0000_0000;
    s_valid  = 1'b1;
    m_ready  = 1'b0;
    rsp_done = 1'b0;
    @(posedge ACLK);
    #1;
    checkOutput("midreset m_valid", 32'(m_valid), 32'd0);
    checkOutput("midreset m_addr", m_addr, 32'd0);
    checkOutput("midreset m_select", 32'(m_select), 32'd0);
    checkOutput("midreset m_decerr", 32'(m_decerr), 32'd0);
    checkOutput("midreset outstanding", 32'(outstanding), 32'd0);
`ifdef AXI_ROUTER_STALL_CNT_EN
    checkOutput("midreset stall_cnt", 32'(stallCnt), 32'd0);
`endif

    // after reset the ordering history is gone: slave1 accepted at once
    ARESETn = 1'b1;
    s_addr  = 32'h0001_0000;
    s_valid = 1'b1;
    m_ready = 1'b1;
    #1;
    checkOutput("postreset s_ready", 32'(s_ready), 32'd1);
    @(posedge ACLK);
    #1;
    checkOutput("postreset m_valid", 32'(m_valid), 32'd1);
    checkOutput("postreset m_select", 32'(m_select), 32'b010);
    checkOutput("postreset outstanding", 32'(outstanding), 32'd1);

`ifdef AXI_ROUTER_STALL_CNT_EN
    // slave0 request held against slave1 in flight stalls every cycle
    s_addr = 32'h0000_0000;
    for (int i = 0; i < 65540; i++) begin
      @(posedge ACLK);
    end
    #1;
    checkOutput("stall_cnt saturation", 32'(stallCnt), 32'h0000_FFFF);
`endif

    s_valid = 1'b0;
    @(posedge ACLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
